// File: rtl/integrate_dump_accumulator.sv
// Integrate-and-dump accumulator: sums ACC_LEN signed samples at full precision and
// presents the frame total as a registered word with a one-cycle valid pulse.
module integrate_dump_accumulator #(
  parameter int unsigned DATA_WIDTH_IN = 16,
  parameter int unsigned ACC_LEN       = 8,
  localparam int unsigned ACC_WIDTH    = DATA_WIDTH_IN + $clog2(ACC_LEN),
  localparam int unsigned CNT_WIDTH    = ($clog2(ACC_LEN) > 1) ? $clog2(ACC_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 clear,
  input  logic [DATA_WIDTH_IN-1:0] din,
  input  logic                 din_valid,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic [CNT_WIDTH-1:0] count
);

  if (ACC_LEN < 1) begin : gen_bad_len
    $error("integrate_dump_accumulator: ACC_LEN must be at least 1");
  end

  localparam logic [CNT_WIDTH-1:0] LastCount = CNT_WIDTH'(ACC_LEN - 1);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 valid_q, valid_d;
  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH-1:0] sum;

  assign din_ext = ACC_WIDTH'($signed(din));
  assign sum     = acc_q + din_ext;

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    // Clear beats a coincident final sample; dout keeps the previous frame.
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (ena && din_valid) begin
      if (count_q == LastCount) begin
        dout_d  = sum;
        valid_d = 1'b1;
        acc_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = sum;
        count_d = count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign count      = count_q;

endmodule

// File: tb/tb_integrate_dump_accumulator.sv
// Bench for integrate_dump_accumulator: ACC_LEN=4 and ACC_LEN=1 instances share stimulus
// and are compared each cycle against queue-based frame models.
module tb_integrate_dump_accumulator;

  logic       clk = 1'b0;
  logic       rst, ena, clear, din_valid;
  logic [7:0] din;

  logic [9:0] dout4;
  logic       valid4;
  logic [1:0] count4;
  logic [7:0] dout1;
  logic       valid1;
  logic [0:0] count1;

  int checks = 0;
  int errors = 0;

  // Reference: each model holds the valid samples of the open frame.
  int q4[$];
  int q1[$];
  int exp_dout4, exp_dout1;
  int exp_valid4, exp_valid1;

  integrate_dump_accumulator #(.DATA_WIDTH_IN(8), .ACC_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .din(din), .din_valid(din_valid),
    .dout(dout4), .dout_valid(valid4), .count(count4)
  );

  integrate_dump_accumulator #(.DATA_WIDTH_IN(8), .ACC_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .din(din), .din_valid(din_valid),
    .dout(dout1), .dout_valid(valid1), .count(count1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("dout4", int'($signed(dout4)), exp_dout4);
    check_eq("valid4", int'(valid4), exp_valid4);
    check_eq("count4", int'(count4), q4.size());
    check_eq("dout1", int'($signed(dout1)), exp_dout1);
    check_eq("valid1", int'(valid1), exp_valid1);
    check_eq("count1", int'(count1), q1.size());
  endtask

  task automatic model_edge();
    int s;
    int sum;
    s = int'($signed(din));
    exp_valid4 = 0;
    exp_valid1 = 0;
    if (clear) begin
      q4.delete();
      q1.delete();
    end else if (ena && din_valid) begin
      q4.push_back(s);
      if (q4.size() == 4) begin
        sum = 0;
        foreach (q4[i]) sum += q4[i];
        exp_dout4  = sum;
        exp_valid4 = 1;
        q4.delete();
      end
      q1.push_back(s);
      exp_dout1  = q1[0];
      exp_valid1 = 1;
      q1.delete();
    end
  endtask

  task automatic step(input logic c, input logic e, input logic v, input int d);
    clear     = c;
    ena       = e;
    din_valid = v;
    din       = 8'(d);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic sample(input int d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 0);
  endtask

  // Reset pulse placed between edges; outputs must drop without waiting for a clock.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    q4.delete();
    q1.delete();
    exp_dout4  = 0;
    exp_dout1  = 0;
    exp_valid4 = 0;
    exp_valid1 = 0;
    check_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    clear = 1'b0;
    din_valid = 1'b0;
    din = '0;
    exp_dout4 = 0;
    exp_dout1 = 0;
    exp_valid4 = 0;
    exp_valid1 = 0;
    #12;
    check_all();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame
    for (int i = 1; i <= 4; i++) sample(i);
    idle();
    // Extremes back-to-back
    repeat (4) sample(-128);
    repeat (4) sample(127);
    idle();
    // Gaps and enable low
    sample(5);
    idle();
    sample(5);
    step(1'b0, 1'b0, 1'b1, 99);
    sample(5);
    sample(5);
    idle();
    // Clear with a coincident sample
    sample(7);
    sample(7);
    step(1'b1, 1'b1, 1'b1, 7);
    repeat (4) sample(1);
    idle();
    // Clear together with the frame's final sample
    repeat (3) sample(9);
    step(1'b1, 1'b1, 1'b1, 9);
    idle();
    // Asynchronous reset mid-frame
    sample(3);
    sample(3);
    pulse_reset();
    repeat (4) sample(2);
    idle();
    // Consecutive single-sample dumps
    sample(-3);
    sample(9);
    idle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset();
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
